// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALU/mux select codes and the bundle of control outputs.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Signal bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
           illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath: Moore decode of the state
// register, with pc_en gated by zero in BEQ and memory strobes gated by mem_ready.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_main_control_if.master      bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   ready;

  assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; the combinational block below uses blocking only.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d = FETCH;
    ctrl    = '0;
    unique case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = ready;
        ctrl.pc_en     = ready;
        state_d        = ready ? DECODE : FETCH;
      end
      DECODE: begin
        ctrl.alu_src_b = ALUB_BRANCH;
        ctrl.alu_op    = ALUOP_ADD;
        unique case (bus.opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d         = FETCH;
            ctrl.illegal_op = 1'b1;
            ctrl.instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        state_d       = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = ready;
        state_d         = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = ALUB_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.pc_en      = bus.zero;
        ctrl.instr_done = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;  // encodings 12-15 recover to FETCH with everything off
    endcase
    // Reset blanks all outputs in the reset cycle so an abandoned
    // instruction cannot write anything.
    if (rst) ctrl = '0;
  end

  assign bus.pc_en      = ctrl.pc_en;
  assign bus.iord       = ctrl.iord;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.instr_done = ctrl.instr_done;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.state      = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed cycle-by-cycle bench for multicycle_main_control with hand-written
// expected state and control vectors.
module tb_multicycle_main_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  multicycle_main_control_if bus_if ();

  multicycle_main_control #(.USE_MEM_READY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Control vector bit order:
  // pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a
  // _ alu_src_b[1:0] alu_op[1:0] pc_source[1:0] _ instr_done illegal_op
  localparam logic [16:0] V_OFF      = 17'b000000000_000000_00;
  localparam logic [16:0] V_FETCH    = 17'b101010000_010000_00;
  localparam logic [16:0] V_FETCH_W  = 17'b001000000_010000_00;
  localparam logic [16:0] V_DECODE   = 17'b000000000_110000_00;
  localparam logic [16:0] V_DEC_ILL  = 17'b000000000_110000_11;
  localparam logic [16:0] V_MEMADR   = 17'b000000001_100000_00;
  localparam logic [16:0] V_MEMRD    = 17'b011000000_000000_00;
  localparam logic [16:0] V_MEMWB    = 17'b000000110_000000_10;
  localparam logic [16:0] V_MEMWR    = 17'b010100000_000000_10;
  localparam logic [16:0] V_EXEC     = 17'b000000001_001000_00;
  localparam logic [16:0] V_ALUWB    = 17'b000001010_000000_10;
  localparam logic [16:0] V_BEQ_T    = 17'b100000001_000101_10;
  localparam logic [16:0] V_BEQ_N    = 17'b000000001_000101_10;
  localparam logic [16:0] V_ADDIEX   = 17'b000000001_100000_00;
  localparam logic [16:0] V_ADDIWB   = 17'b000000010_000000_10;
  localparam logic [16:0] V_JUMP     = 17'b100000000_000010_10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] observed();
    return {bus_if.pc_en, bus_if.iord, bus_if.mem_read, bus_if.mem_write,
            bus_if.ir_write, bus_if.reg_dst, bus_if.mem_to_reg, bus_if.reg_write,
            bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.pc_source,
            bus_if.instr_done, bus_if.illegal_op};
  endfunction

  // Apply inputs just after a rising edge, sample at the falling edge, then
  // advance to just past the next rising edge.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic z,
                     input logic [3:0] exp_state, input logic [16:0] exp_ctrl);
    rst              = r;
    bus_if.mem_ready = rdy;
    bus_if.zero      = z;
    @(negedge clk);
    check({tag, ".state"}, 32'(bus_if.state), 32'(exp_state));
    check({tag, ".ctrl"},  32'(observed()),   32'(exp_ctrl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.opcode    = 6'b000000;
    bus_if.zero      = 1'b0;
    bus_if.mem_ready = 1'b1;
    #1;

    // Reset for two cycles: everything forced to zero.
    cyc("rst_a", 1'b1, 1'b1, 1'b0, 4'd0, V_OFF);
    cyc("rst_b", 1'b1, 1'b1, 1'b0, 4'd0, V_OFF);

    // R-type: 0,1,6,7
    cyc("r_fetch",  1'b0, 1'b1, 1'b0, 4'd0, V_FETCH);
    cyc("r_decode", 1'b0, 1'b1, 1'b0, 4'd1, V_DECODE);
    cyc("r_exec",   1'b0, 1'b1, 1'b0, 4'd6, V_EXEC);
    cyc("r_aluwb",  1'b0, 1'b1, 1'b0, 4'd7, V_ALUWB);

    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    bus_if.opcode = 6'b100011;
    cyc("lw_fetch",  1'b0, 1'b1, 1'b0, 4'd0, V_FETCH);
    cyc("lw_decode", 1'b0, 1'b1, 1'b0, 4'd1, V_DECODE);
    cyc("lw_memadr", 1'b0, 1'b1, 1'b0, 4'd2, V_MEMADR);
    cyc("lw_memrd0", 1'b0, 1'b0, 1'b0, 4'd3, V_MEMRD);
    cyc("lw_memrd1", 1'b0, 1'b0, 1'b0, 4'd3, V_MEMRD);
    cyc("lw_memrd2", 1'b0, 1'b1, 1'b0, 4'd3, V_MEMRD);
    cyc("lw_memwb",  1'b0, 1'b1, 1'b0, 4'd4, V_MEMWB);

    // sw with no wait: 0,1,2,5
    bus_if.opcode = 6'b101011;
    cyc("sw_fetch",  1'b0, 1'b1, 1'b0, 4'd0, V_FETCH);
    cyc("sw_decode", 1'b0, 1'b1, 1'b0, 4'd1, V_DECODE);
    cyc("sw_memadr", 1'b0, 1'b1, 1'b0, 4'd2, V_MEMADR);
    cyc("sw_memwr",  1'b0, 1'b1, 1'b0, 4'd5, V_MEMWR);

    // beq taken, then not taken
    bus_if.opcode = 6'b000100;
    cyc("beqt_fetch",  1'b0, 1'b1, 1'b0, 4'd0, V_FETCH);
    cyc("beqt_decode", 1'b0, 1'b1, 1'b0, 4'd1, V_DECODE);
    cyc("beqt_beq",    1'b0, 1'b1, 1'b1, 4'd8, V_BEQ_T);
    cyc("beqn_fetch",  1'b0, 1'b1, 1'b0, 4'd0, V_FETCH);
    cyc("beqn_decode", 1'b0, 1'b1, 1'b0, 4'd1, V_DECODE);
    cyc("beqn_beq",    1'b0, 1'b1, 1'b0, 4'd8, V_BEQ_N);

    // Unsupported opcode: 0,1 then straight back to FETCH
    bus_if.opcode = 6'b111111;
    cyc("ill_fetch",  1'b0, 1'b1, 1'b0, 4'd0, V_FETCH);
    cyc("ill_decode", 1'b0, 1'b1, 1'b0, 4'd1, V_DEC_ILL);

    // addi with one FETCH wait cycle: 0,0,1,9,10
    bus_if.opcode = 6'b001000;
    cyc("addi_fetchw", 1'b0, 1'b0, 1'b0, 4'd0,  V_FETCH_W);
    cyc("addi_fetch",  1'b0, 1'b1, 1'b0, 4'd0,  V_FETCH);
    cyc("addi_decode", 1'b0, 1'b1, 1'b0, 4'd1,  V_DECODE);
    cyc("addi_ex",     1'b0, 1'b1, 1'b0, 4'd9,  V_ADDIEX);
    cyc("addi_wb",     1'b0, 1'b1, 1'b0, 4'd10, V_ADDIWB);

    // lw abandoned by reset while waiting in MEMRD
    bus_if.opcode = 6'b100011;
    cyc("lwr_fetch",  1'b0, 1'b1, 1'b0, 4'd0, V_FETCH);
    cyc("lwr_decode", 1'b0, 1'b1, 1'b0, 4'd1, V_DECODE);
    cyc("lwr_memadr", 1'b0, 1'b1, 1'b0, 4'd2, V_MEMADR);
    cyc("lwr_memrd",  1'b0, 1'b0, 1'b0, 4'd3, V_MEMRD);
    cyc("lwr_rst",    1'b1, 1'b1, 1'b0, 4'd0, V_OFF);

    // Restart after reset with a jump: 0,1,11,0
    bus_if.opcode = 6'b000010;
    cyc("j_fetch",  1'b0, 1'b1, 1'b0, 4'd0,  V_FETCH);
    cyc("j_decode", 1'b0, 1'b1, 1'b0, 4'd1,  V_DECODE);
    cyc("j_jump",   1'b0, 1'b1, 1'b0, 4'd11, V_JUMP);
    cyc("j_next",   1'b0, 1'b0, 1'b0, 4'd0,  V_FETCH_W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the instruction opcode and sequences the datapath enables and muxes across fetch/decode/execute/memory/writeback states.
- Produces the 2-bit alu_op that feeds the downstream ALU-control decoder: 00 = add, 01 = subtract, 10 = decode funct.
- Handshakes with a variable-latency memory through mem_ready.

Parameters:
- USE_MEM_READY, 1, when 1 the memory states wait for mem_ready; when 0 mem_ready is treated as constantly 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BEQ
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  register write address: 0 = rt, 1 = rd
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2
- alu_op  out  2  to ALU-control decoder
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- state  out  4  current state, for debug

Behaviour:
- Single clock domain, clk. Reset rst is synchronous, active-high.
- While rst=1 at a rising edge: next state = FETCH, and every output is 0 during that cycle (combinationally forced). Reset mid-instruction abandons the instruction; there are no partial writes after the reset edge.
- Moore FSM. Outputs are decoded from the state register. Exceptions: pc_en in BEQ depends on zero; memory-state enables depend on mem_ready.
- Signals not listed for a state are 0.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_en = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - alu_src_b=11, alu_op=00 (branch target computed into ALUOut).
  - Next state by opcode: 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 and instr_done=1.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD if opcode=100011, else MEMWR.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready=1; instr_done=mem_ready; then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero, instr_done=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1. Next state FETCH.
- Cycle counts with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_read and mem_write are never both 1. reg_write and pc_en are never both 1 in the same cycle.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Unused state encodings (12-15) -> FETCH next cycle with all outputs 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11;
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - alu_op constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - alu_src_b and pc_source select constants.
- The ALU-control decoder imports the same alu_op constants.
- No sub-module: the next-state logic and the output decode live in this one module.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 and opcode=000000 -> all outputs 0 during reset; state sequence 0,1,6,7,0; alu_op=10 in EXEC; reg_write=1 with reg_dst=1 in ALUWB; instr_done pulses once.
- lw (100011), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iord=1 throughout MEMRD; reg_write=1 with mem_to_reg=1 only in MEMWB.
- sw (101011), mem_ready=1 -> states 0,1,2,5,0; mem_write=1 for exactly one cycle; reg_write is never 1.
- beq (000100) with zero=1, then again with zero=0 -> alu_op=01 and pc_source=01 in BEQ; pc_en=1 in the first case, 0 in the second.
- Opcode 111111 -> states 0,1,0; illegal_op and instr_done both pulse in DECODE; no reg_write or mem_write.
- rst asserted during MEMRD of an lw -> state=0 after the edge; reg_write never asserted for that lw; FETCH restarts normally.
